// File: rtl/truth_table_sequencer.sv
// Exhaustive truth-table sweep comparing a reference function against a
// simplified implementation. The block drives every input vector in ascending
// order, waits SETTLE cycles for the checked logic to settle, then samples the
// two function outputs and records mismatches.
module truth_table_sequencer #(
  parameter int unsigned N_IN   = 5,
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            stop_on_fail,
  output logic [N_IN-1:0] vec,
  input  logic            m_ref,
  input  logic            m_imp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_e;

  // WAIT lasts SETTLE cycles: the counter runs from SETTLE-1 down to 0.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            sof_q, sof_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            fv_q, fv_d;
  logic            mismatch;
  logic            last_vec;

  assign mismatch = (m_ref != m_imp);
  assign last_vec = (vec_q == '1);

  // Next-state and next-output computation for the sweep controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sof_d   = sof_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fv_d    = fv_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
          sof_d   = stop_on_fail;
          cnt_d   = SETTLE_LOAD;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (abort) begin
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_SAMPLE: begin
        // Abort takes priority: the pending sample is discarded entirely.
        if (abort) begin
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (mismatch) begin
            err_d = err_q + (N_IN+1)'(1);
            if (!fv_q) begin
              ff_d = vec_q;
              fv_d = 1'b1;
            end
          end
          if (last_vec || (mismatch && sof_q)) begin
            // pass is resolved here so it already reflects the final sample
            // during the done cycle.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_q == '0) && !mismatch;
            state_d = S_DONE;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            cnt_d   = SETTLE_LOAD;
            state_d = S_WAIT;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sof_q   <= 1'b0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sof_q   <= sof_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
    end
  end

  assign vec        = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;
  assign fail_valid = fv_q;

endmodule
